// File: rtl/stage_burn_pkg.sv
// -----------------------------------------------------------------------------
// stage_burn_pkg
//   Shared types and constants for the stage burn responder.
//   - state_t : top-level burn sequencer states
//   - phase_t : sub-steps inside the two divide states
//   - GRAVITY_DEFAULT / TICKS_DEFAULT : default model constants
//   - div_latency() : start-to-done cycle count of the sequential divider
// -----------------------------------------------------------------------------
package stage_burn_pkg;

   // g0 in mm/s^2 (scale factor 1e-3)
   localparam int GRAVITY_DEFAULT = 9_799;

   // clk cycles per simulated second; must cover the divider latency plus margin
   localparam int TICKS_DEFAULT = 68;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RATE_DIV,
      S_BURN,
      S_ACC_DIV,
      S_UPDATE,
      S_DONE
   } state_t;

   // PH_MUL1/PH_MUL2 are only used by RATE_DIV for the two-step k product
   typedef enum logic [1:0] {
      PH_START,
      PH_WAIT,
      PH_MUL1,
      PH_MUL2
   } phase_t;

   // One capture cycle followed by one restoring step per quotient bit
   function automatic int div_latency(input int n);
      return n + 1;
   endfunction

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   N-bit restoring divider, one quotient bit per cycle.
//   start is sampled in any cycle; operands are captured on that edge and
//   done pulses for one cycle div_latency(N) edges later. quotient/remainder
//   stay stable until the next start. Division by zero returns q=0, r=0.
// Ports
//   clk        in   1  clock
//   resetb     in   1  async active-low reset
//   start      in   1  capture operands and begin a division
//   dividend   in   N  numerator
//   divisor    in   N  denominator
//   done       out  1  1-cycle pulse, results valid
//   quotient   out  N  floor(dividend / divisor)
//   remainder  out  N  dividend mod divisor
// -----------------------------------------------------------------------------
module seq_divider
   import stage_burn_pkg::*;
#(
   parameter int N = 64
) (
   input  logic         clk,
   input  logic         resetb,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder
);

   localparam int LATENCY = div_latency(N);
   localparam int CW      = $clog2(LATENCY);

   logic [N-1:0]  den;
   logic [N-1:0]  quo;
   logic [N-1:0]  rem;
   logic [CW-1:0] count;
   logic          running;
   logic          zero_div;
   logic [N:0]    trial;
   logic [N:0]    diff;

   // Shift the next dividend bit into the partial remainder and try to
   // subtract. rem < den always holds, so trial - den < 2^N whenever it is
   // non-negative: diff[N] is a pure borrow flag.
   always_comb begin
      trial = {rem, quo[N-1]};
      diff  = trial - {1'b0, den};
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         den      <= '0;
         quo      <= '0;
         rem      <= '0;
         count    <= '0;
         running  <= 1'b0;
         zero_div <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            den      <= divisor;
            quo      <= dividend;
            rem      <= '0;
            count    <= CW'(LATENCY - 1);
            running  <= 1'b1;
            zero_div <= (divisor == '0);
         end else if (running) begin
            if (diff[N]) begin
               rem <= trial[N-1:0];
               quo <= {quo[N-2:0], 1'b0};
            end else begin
               rem <= diff[N-1:0];
               quo <= {quo[N-2:0], 1'b1};
            end
            count <= count - CW'(1);
            if (count == CW'(1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

   assign quotient  = zero_div ? '0 : quo;
   assign remainder = zero_div ? '0 : rem;

endmodule

// File: rtl/stage_burn_responder.sv
// -----------------------------------------------------------------------------
// stage_burn_responder
//   Burns one rocket stage: on load, latches Isp / masses / burn time, derives
//   the mass flow mdot and thrust constant k = Isp*g0*mdot, then for each
//   simulated second integrates a = k / mass into velocity and depletes mass.
//   ignition_end pulses for one cycle when the last second completes.
//
//   Cycle timing (E0 = edge that samples load, c = cycles after E0):
//     RATE_DIV occupies c = 0 .. N+3, first BURN cycle at c = N+4.
//     Each simulated second takes TICKS_PER_SEC + N + 3 cycles
//     (BURN TICKS_PER_SEC, ACC_DIV N+2, UPDATE 1).
//     ignition_end is high at c = (N+4) + burntime*(TICKS_PER_SEC+N+3),
//     or at c = 1 when burntime == 0. hold cycles in BURN add one each.
// Ports
//   clk                in   1  clock
//   resetb             in   1  async active-low reset
//   load               in   1  capture stage params (honoured only in IDLE)
//   hold               in   1  freeze the per-second tick counter
//   specific_impulse   in   N  Isp, s
//   initial_weight     in   N  stage-start mass, kg
//   propellant_weight  in   N  propellant burned this stage, kg
//   burntime           in   N  burn duration, whole seconds
//   busy               out  1  burn in progress
//   velocity           out  N  cumulative velocity, mm/s (saturating)
//   after_weight       out  N  current mass, kg
//   ignition_end       out  1  1-cycle pulse, burn complete
// -----------------------------------------------------------------------------
module stage_burn_responder
   import stage_burn_pkg::*;
#(
   parameter int N             = 64,
   parameter int GRAVITY       = GRAVITY_DEFAULT,
   parameter int TICKS_PER_SEC = TICKS_DEFAULT
) (
   input  logic         clk,
   input  logic         resetb,
   input  logic         load,
   input  logic         hold,
   input  logic [N-1:0] specific_impulse,
   input  logic [N-1:0] initial_weight,
   input  logic [N-1:0] propellant_weight,
   input  logic [N-1:0] burntime,
   output logic         busy,
   output logic [N-1:0] velocity,
   output logic [N-1:0] after_weight,
   output logic         ignition_end
);

   localparam int          TW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

   state_t state, next_state;
   phase_t phase, next_phase;

   logic [N-1:0]  isp;
   logic [N-1:0]  prop;
   logic [N-1:0]  bt;
   logic [N-1:0]  mdot;
   logic [N-1:0]  mdot_rem;
   logic [N-1:0]  k;
   logic [N-1:0]  seconds;
   logic [TW-1:0] tick;

   logic          div_start;
   logic [N-1:0]  div_dividend;
   logic [N-1:0]  div_divisor;
   logic          div_done;
   logic [N-1:0]  div_q;
   logic [N-1:0]  div_r;

   logic [N-1:0]  seconds_inc;
   logic          last_second;
   logic [N:0]    vel_sum;
   logic [N-1:0]  vel_next;

   seq_divider #(.N(N)) u_div (
      .clk       (clk),
      .resetb    (resetb),
      .start     (div_start),
      .dividend  (div_dividend),
      .divisor   (div_divisor),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
   );

   assign seconds_inc = seconds + N'(1);
   assign last_second = (seconds_inc == bt);

   // Saturating accumulate; div_q still holds this second's acceleration
   assign vel_sum  = {1'b0, velocity} + {1'b0, div_q};
   assign vel_next = vel_sum[N] ? '1 : vel_sum[N-1:0];

   assign ignition_end = (state == S_DONE);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state <= S_IDLE;
         phase <= PH_START;
      end else begin
         state <= next_state;
         phase <= next_phase;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      next_state   = state;
      next_phase   = phase;
      div_start    = 1'b0;
      div_dividend = prop;
      div_divisor  = bt;
      case (state)
         S_IDLE: begin
            if (load) begin
               next_state = S_RATE_DIV;
               next_phase = PH_START;
            end
         end
         S_RATE_DIV: begin
            case (phase)
               PH_START: begin
                  if (bt == '0) begin
                     next_state = S_DONE;
                  end else begin
                     div_start  = 1'b1;
                     next_phase = PH_WAIT;
                  end
               end
               PH_WAIT: if (div_done) next_phase = PH_MUL1;
               PH_MUL1: next_phase = PH_MUL2;
               default: next_state = S_BURN;
            endcase
         end
         S_BURN: begin
            if (!hold && tick == TICK_LAST) begin
               next_state = S_ACC_DIV;
               next_phase = PH_START;
            end
         end
         S_ACC_DIV: begin
            // Start-of-second mass; divider returns 0 if it is zero
            div_dividend = k;
            div_divisor  = after_weight;
            if (phase == PH_START) begin
               div_start  = 1'b1;
               next_phase = PH_WAIT;
            end else if (div_done) begin
               next_state = S_UPDATE;
            end
         end
         S_UPDATE: next_state = last_second ? S_DONE : S_BURN;
         S_DONE:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------ datapath
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         isp          <= '0;
         prop         <= '0;
         bt           <= '0;
         mdot         <= '0;
         mdot_rem     <= '0;
         k            <= '0;
         seconds      <= '0;
         tick         <= '0;
         busy         <= 1'b0;
         velocity     <= '0;
         after_weight <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (load) begin
                  isp          <= specific_impulse;
                  prop         <= propellant_weight;
                  bt           <= burntime;
                  after_weight <= initial_weight;
                  seconds      <= '0;
                  tick         <= '0;
                  busy         <= 1'b1;
               end
            end
            S_RATE_DIV: begin
               case (phase)
                  PH_WAIT: begin
                     if (div_done) begin
                        mdot     <= div_q;
                        mdot_rem <= div_r;
                     end
                  end
                  PH_MUL1: k <= isp * N'(GRAVITY);
                  PH_MUL2: k <= k * mdot;
                  default: ;
               endcase
            end
            S_BURN: begin
               if (!hold) tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
            end
            S_UPDATE: begin
               velocity <= vel_next;
               // Final second also removes the division remainder so the
               // stage ends at exactly initial - propellant.
               after_weight <= last_second ? after_weight - (mdot + mdot_rem)
                                           : after_weight - mdot;
               seconds <= seconds_inc;
            end
            S_DONE:  busy <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stage_burn_responder.sv
// -----------------------------------------------------------------------------
// tb_stage_burn_responder
//   Directed bench for stage_burn_responder (N=64, g0=9799, 68 ticks/s).
//   Timing used below (E0 = edge sampling load, c = cycles after E0):
//     first second's results visible at c = 68 + 135 = 203
//     ignition_end at c = 68 + 135*burntime, or c = 1 when burntime == 0
// -----------------------------------------------------------------------------
module tb_stage_burn_responder;

   localparam int N       = 64;
   localparam int GRAVITY = 9_799;
   localparam int S1_C    = 203;

   logic         clk = 1'b0;
   logic         resetb;
   logic         load;
   logic         hold;
   logic [N-1:0] specific_impulse;
   logic [N-1:0] initial_weight;
   logic [N-1:0] propellant_weight;
   logic [N-1:0] burntime;
   logic         busy;
   logic [N-1:0] velocity;
   logic [N-1:0] after_weight;
   logic         ignition_end;

   stage_burn_responder dut (
      .clk               (clk),
      .resetb            (resetb),
      .load              (load),
      .hold              (hold),
      .specific_impulse  (specific_impulse),
      .initial_weight    (initial_weight),
      .propellant_weight (propellant_weight),
      .burntime          (burntime),
      .busy              (busy),
      .velocity          (velocity),
      .after_weight      (after_weight),
      .ignition_end      (ignition_end)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] isp;
      logic [63:0] m0;
      logic [63:0] prop;
      logic [63:0] bt;
      logic [63:0] v1;    // velocity gained in second 1
      logic [63:0] w1;    // mass after second 1
      logic [63:0] wend;  // mass at ignition_end
      int          lat;   // c at which ignition_end is high
   } vec_t;

   vec_t        vecs [6];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] v_exp    = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, exp, exp);
      end
   endtask

   // Reference: sum over seconds of floor(k / start-of-second mass)
   function automatic logic [63:0] model_dv(input vec_t v);
      logic [63:0] mdot, k, m, sum;
      sum = '0;
      if (v.bt == 0) return sum;
      mdot = v.prop / v.bt;
      k    = v.isp * 64'(GRAVITY) * mdot;
      m    = v.m0;
      for (longint unsigned i = 0; i < v.bt; i++) begin
         if (m != 0) sum += k / m;
         m -= mdot;
      end
      return sum;
   endfunction

   task automatic apply_load(input vec_t v);
      @(negedge clk);
      specific_impulse  = v.isp;
      initial_weight    = v.m0;
      propellant_weight = v.prop;
      burntime          = v.bt;
      load              = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Runs one stage; optional hold window [hold_start, hold_start+hold_len)
   task automatic run_stage(input string tag, input vec_t v, input int hold_start, input int hold_len);
      int          c;
      int          fire_at;
      int          exp_lat;
      logic [63:0] dv;
      dv      = model_dv(v);
      exp_lat = v.lat + hold_len;
      fire_at = -1;
      apply_load(v);
      c = 0;
      while (fire_at < 0 && c <= exp_lat + 50) begin
         if (c == 0) check({tag, " busy_rise"}, 64'(busy), 64'd1);
         if (v.bt != 0 && c == S1_C) begin
            check({tag, " s1_velocity"}, velocity, v_exp + v.v1);
            check({tag, " s1_weight"}, after_weight, v.w1);
         end
         if (hold_len > 0 && c == hold_start) hold = 1'b1;
         if (hold_len > 0 && c == hold_start + hold_len) begin
            check({tag, " held_velocity"}, velocity, v_exp + v.v1);
            check({tag, " held_weight"}, after_weight, v.w1);
            hold = 1'b0;
         end
         if (ignition_end) begin
            fire_at = c;
         end else begin
            @(negedge clk);
            c++;
         end
      end
      check({tag, " latency"}, 64'(fire_at), 64'(exp_lat));
      check({tag, " end_velocity"}, velocity, v_exp + dv);
      check({tag, " end_weight"}, after_weight, v.wend);
      @(negedge clk);
      check({tag, " pulse_width"}, 64'(ignition_end), 64'd0);
      check({tag, " busy_fall"}, 64'(busy), 64'd0);
      v_exp = v_exp + dv;
      hold  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   pulses;
      vec_t bad;

      //          isp  m0        prop      bt   v1      w1                      wend                    lat
      vecs[0] = '{100, 1000,     500,      5,   97990,  900,                    500,                    743};
      vecs[1] = '{100, 1000,     500,      5,   97990,  900,                    500,                    743};
      vecs[2] = '{263, 2875403,  2077000,  168, 11080,  2863040,                798403,                 22748};
      vecs[3] = '{100, 1234,     5,        0,   0,      0,                      1234,                   1};
      vecs[4] = '{300, 5000,     1003,     4,   146985, 4750,                   3997,                   608};
      vecs[5] = '{1,   0,        10,       2,   0,      64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF6, 338};

      resetb = 1'b0; load = 1'b0; hold = 1'b0;
      specific_impulse = '0; initial_weight = '0; propellant_weight = '0; burntime = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset velocity", velocity, 64'd0);
      check("reset weight", after_weight, 64'd0);
      check("reset ignition_end", 64'(ignition_end), 64'd0);
      resetb = 1'b1;

      // Entries 0 and 1 are back-to-back identical stages: velocity carries over
      for (int i = 0; i < 6; i++) run_stage($sformatf("vec%0d", i), vecs[i], 0, 0);

      // Hold for three simulated seconds inside the second BURN window
      run_stage("hold", vecs[0], 210, 204);

      // Load during burn is ignored; reset mid-burn clears everything
      bad = '{7, 77, 7, 1, 0, 0, 0, 0};
      apply_load(vecs[0]);
      for (int c = 0; c < 300; c++) begin
         if (c == 150) begin
            specific_impulse = bad.isp; initial_weight = bad.m0;
            propellant_weight = bad.prop; burntime = bad.bt;
            load = 1'b1;
         end
         if (c == 151) load = 1'b0;
         if (c == S1_C) begin
            check("midload s1_velocity", velocity, v_exp + 64'd97990);
            check("midload s1_weight", after_weight, 64'd900);
         end
         @(negedge clk);
      end
      resetb = 1'b0;
      #1;
      check("midreset velocity", velocity, 64'd0);
      check("midreset weight", after_weight, 64'd0);
      check("midreset busy", 64'(busy), 64'd0);
      @(negedge clk);
      resetb = 1'b1;
      v_exp  = '0;
      pulses = 0;
      for (int c = 0; c < 1000; c++) begin
         if (ignition_end) pulses++;
         @(negedge clk);
      end
      check("midreset no_ignition", 64'(pulses), 64'd0);

      // Recovery after reset: velocity restarts from zero
      run_stage("after_reset", vecs[0], 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
